// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP datapath: FSM state encoding plus
// wide-format ReLU and saturation used by each output lane.
package mlp_pkg;

  typedef enum logic [1:0] {IDLE, ACC, BIAS, OUT} state_e;

  localparam int WIDE = 64;

  function automatic logic signed [WIDE-1:0] relu(input logic signed [WIDE-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

  // Clamp to the signed range of an nb-bit value.
  function automatic logic signed [WIDE-1:0] sat(input logic signed [WIDE-1:0] v,
                                                 input int nb);
    logic signed [WIDE-1:0] hi, lo;
    hi = (64'sd1 <<< (nb - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nb - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One output lane of the dense layer: signed multiply-accumulate with
// synchronous clear (on accept) and enable (during accumulation).
module mac_lane #(
  parameter int NBits   = 8,
  parameter int AccBits = 2*NBits + 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [NBits-1:0]   a,
  input  logic signed [NBits-1:0]   b,
  output logic signed [AccBits-1:0] acc
);

  logic signed [2*NBits-1:0] prod;
  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + AccBits'(prod);
  end

endmodule

// File: rtl/mac_dense_layer.sv
// Fully connected layer: D2 parallel MAC lanes stepping over D1 inputs,
// then shift/bias/activation/saturate. Define MLP_DENSE_RELU_EN for ReLU.
module mac_dense_layer
  import mlp_pkg::*;
#(
  parameter int NBits    = 8,
  parameter int D1       = 4,
  parameter int D2       = 4,
  parameter int FracBits = 0,
  parameter int AccBits  = 2*NBits + $clog2(D1) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [D1-1:0][NBits-1:0]         din,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [D1-1:0][D2-1:0][NBits-1:0] weights,
  input  logic [D2-1:0][NBits-1:0]         biases,
  output logic [D2-1:0][NBits-1:0]         dout,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int CW = (D1 > 1) ? $clog2(D1) : 1;

  state_e                   state, state_nx;
  logic [CW-1:0]            cnt;
  logic [D1-1:0][NBits-1:0] din_q;
  logic                     accept, last;
  logic signed [AccBits-1:0] acc [D2];
  logic [D2-1:0][NBits-1:0] res;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(D1 - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ACC;
      end
      ACC:  if (last) state_nx = BIAS;
      BIAS: state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      din_q <= '0;
      dout  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        din_q <= din;
        cnt   <= '0;
      end else if (state == ACC && !last) begin
        cnt <= cnt + 1'b1;
      end
      if (state == BIAS) dout <= res;
    end
  end

  for (genvar j = 0; j < D2; j++) begin : g_lane
    logic signed [WIDE-1:0] pre, act;

    mac_lane #(.NBits(NBits), .AccBits(AccBits)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (state == ACC),
      .a     (din_q[cnt]),
      .b     (weights[cnt][j]),
      .acc   (acc[j])
    );

    // Arithmetic shift floors toward minus infinity before the bias is added.
    assign pre = (WIDE'(acc[j]) >>> FracBits) + WIDE'($signed(biases[j]));
`ifdef MLP_DENSE_RELU_EN
    assign act = relu(pre);
`else
    assign act = pre;
`endif
    assign res[j] = NBits'(sat(act, NBits));
  end

endmodule

// File: tb/tb_mac_dense_layer.sv
// Directed bench: main instance (D1=4, D2=2) plus a fixed-point instance (D1=1, FracBits=4).
module tb_mac_dense_layer;

`ifdef MLP_DENSE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][7:0]      din;
  logic [3:0][1:0][7:0] weights;
  logic [1:0][7:0]      biases;
  logic [1:0][7:0]      dout;
  logic                 in_valid, in_ready, out_valid, out_ready;

  logic [0:0][7:0]      fx_din;
  logic [0:0][0:0][7:0] fx_w;
  logic [0:0][7:0]      fx_b;
  logic [0:0][7:0]      fx_dout;
  logic                 fx_in_valid, fx_in_ready, fx_out_valid, fx_out_ready;

  int n_run = 0;
  int n_fail = 0;

  mac_dense_layer #(.NBits(8), .D1(4), .D2(2), .FracBits(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .weights(weights), .biases(biases), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mac_dense_layer #(.NBits(8), .D1(1), .D2(1), .FracBits(4)) u_fx (
    .clk(clk), .rst_n(rst_n), .din(fx_din), .in_valid(fx_in_valid), .in_ready(fx_in_ready),
    .weights(fx_w), .biases(fx_b), .dout(fx_dout), .out_valid(fx_out_valid),
    .out_ready(fx_out_ready)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic load_basic();
    for (int k = 0; k < 4; k++) begin
      din[k]        = 8'(k + 1);
      weights[k][0] = 8'd1;
      weights[k][1] = 8'hFF;
    end
    biases[0] = 8'd5;
    biases[1] = 8'd0;
  endtask

  task automatic fx_run(input logic [7:0] d, input logic [7:0] w, input logic [7:0] b,
                        input longint exp, input string tag);
    int lat;
    fx_din[0] = d; fx_w[0][0] = w; fx_b[0] = b;
    fx_in_valid = 1'b1;
    @(posedge clk); #1;
    fx_in_valid = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (fx_out_valid) break;
    end
    check({tag, "_lat"}, lat, 2);
    check(tag, $signed(fx_dout[0]), exp);
    fx_out_ready = 1'b1;
    @(posedge clk); #1;
    fx_out_ready = 1'b0;
  endtask

  initial begin
    int lat, prev, nres;
    logic [1:0][7:0] held;
    longint neg_exp;
    in_valid = 0; out_ready = 0; din = '0; weights = '0; biases = '0;
    fx_in_valid = 0; fx_out_ready = 0; fx_din = '0; fx_w = '0; fx_b = '0;
    neg_exp = RELU ? 0 : -10;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // basic
    load_basic();
    start();
    wait_out(lat);
    check("basic_lat", lat, 5);
    check("basic_d0", $signed(dout[0]), 15);
    check("basic_d1", $signed(dout[1]), neg_exp);
    ack();

    // saturation, both polarities
    din = {4{8'd127}};
    weights = {8{8'd127}};
    biases = '0;
    start(); wait_out(lat);
    check("satp_d0", $signed(dout[0]), 127);
    check("satp_d1", $signed(dout[1]), 127);
    ack();
    weights = {8{8'h80}};
    start(); wait_out(lat);
    check("satn_d0", $signed(dout[0]), RELU ? 0 : -128);
    check("satn_d1", $signed(dout[1]), RELU ? 0 : -128);
    ack();

    // backpressure with an ignored in_valid
    load_basic();
    start(); wait_out(lat);
    held = dout;
    in_valid = 1'b1;
    din = {4{8'd9}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_dout", dout, held);
    end
    in_valid = 1'b0;
    ack();
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_dout_kept", dout, held);

    // reset at counter 2
    load_basic();
    start();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_dout", dout, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start(); wait_out(lat);
    check("mrst_lat", lat, 5);
    check("mrst_d0", $signed(dout[0]), 15);
    check("mrst_d1", $signed(dout[1]), neg_exp);
    ack();

    // back-to-back streaming
    in_valid = 1'b1;
    out_ready = 1'b1;
    prev = -1;
    nres = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        check("b2b_d0", $signed(dout[0]), 15);
        check("b2b_d1", $signed(dout[1]), neg_exp);
        if (prev >= 0) check("b2b_interval", c - prev, 7);
        prev = c;
        nres++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", nres, 5);

    // fixed point, FracBits=4
    fx_run(8'd16, 8'd8, 8'd2, 10, "fx_pos");
    fx_run(8'hFF, 8'd1, 8'd0, RELU ? 0 : -1, "fx_floor");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
